// File: rtl/hazard_scoreboard_if.sv
// Issue/decision bundle between CU/RD and the hazard scoreboard.
// Decisions are combinational from the issue fields and scoreboard state.
// No handshake of its own: stall is the only backpressure toward the CU.
interface hazard_scoreboard_if #(
    parameter int REG_AW = 5,
    parameter int STAGES = 4
);
    localparam int SW    = $clog2(STAGES + 1);
    localparam int NREGS = 2 ** REG_AW;

    logic              issue_valid;
    logic [REG_AW-1:0] issue_rs;
    logic [REG_AW-1:0] issue_rt;
    logic              issue_rs_use;
    logic              issue_rt_use;
    logic [REG_AW-1:0] issue_rd;
    logic              issue_we;
    logic [SW-1:0]     issue_avail;
    logic              stall;
    logic              fwd_rs_valid;
    logic [SW-1:0]     fwd_rs_stage;
    logic              fwd_rt_valid;
    logic [SW-1:0]     fwd_rt_stage;
    logic [NREGS-1:0]  busy_vec;

    // CU/RD side: presents the instruction, consumes the decisions
    modport master (
        output issue_valid, issue_rs, issue_rt, issue_rs_use, issue_rt_use,
               issue_rd, issue_we, issue_avail,
        input  stall, fwd_rs_valid, fwd_rs_stage, fwd_rt_valid, fwd_rt_stage,
               busy_vec
    );

    // scoreboard side
    modport slave (
        input  issue_valid, issue_rs, issue_rt, issue_rs_use, issue_rt_use,
               issue_rd, issue_we, issue_avail,
        output stall, fwd_rs_valid, fwd_rs_stage, fwd_rt_valid, fwd_rt_stage,
               busy_vec
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register in-flight write tracker issuing stall/forward decisions.
// Decisions are combinational (0 cycles); state updates are visible the cycle after the edge.
// stall holds CU/RD while a producer's result is not yet forwardable; hold freezes all ages.
module hazard_scoreboard #(
    parameter int REG_AW      = 5,
    parameter int STAGES      = 4,
    parameter int FLUSH_DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic hold,
    input  logic flush,
    hazard_scoreboard_if.slave sb
);
    localparam int SW    = $clog2(STAGES + 1);
    localparam int NREGS = 2 ** REG_AW;
    localparam logic [SW-1:0] STAGES_L = SW'(STAGES);
    localparam logic [SW-1:0] FLUSH_L  = SW'(FLUSH_DEPTH);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [SW-1:0]    age_q   [NREGS];
    logic [SW-1:0]    age_d   [NREGS];
    logic [SW-1:0]    avail_q [NREGS];
    logic [SW-1:0]    avail_d [NREGS];

    logic          rs_pend, rt_pend;
    logic          rs_stall, rt_stall;
    logic          accept;
    logic [SW-1:0] avail_clamped;

    // source checks: a pending producer either stalls us or names the forwarding stage
    always_comb begin
        rs_pend  = sb.issue_valid & sb.issue_rs_use & busy_q[sb.issue_rs] & (sb.issue_rs != '0);
        rt_pend  = sb.issue_valid & sb.issue_rt_use & busy_q[sb.issue_rt] & (sb.issue_rt != '0);
        rs_stall = rs_pend & (age_q[sb.issue_rs] < avail_q[sb.issue_rs]);
        rt_stall = rt_pend & (age_q[sb.issue_rt] < avail_q[sb.issue_rt]);

        sb.stall        = rs_stall | rt_stall;
        sb.fwd_rs_valid = rs_pend & ~rs_stall;
        sb.fwd_rt_valid = rt_pend & ~rt_stall;
        sb.fwd_rs_stage = sb.fwd_rs_valid ? age_q[sb.issue_rs] : '0;
        sb.fwd_rt_stage = sb.fwd_rt_valid ? age_q[sb.issue_rt] : '0;
        sb.busy_vec     = busy_q;

        // hold only blocks acceptance; the external stall unit ORs it into stall
        accept = sb.issue_valid & ~sb.stall & ~hold & ~flush;

        // avail of 0 behaves as EX, anything beyond writeback behaves as writeback
        if (sb.issue_avail == '0) begin
            avail_clamped = SW'(1);
        end else if (sb.issue_avail > STAGES_L) begin
            avail_clamped = STAGES_L;
        end else begin
            avail_clamped = sb.issue_avail;
        end
    end

    // next state: flush kill, aging/retire, then the new producer overrides its register
    always_comb begin
        busy_d  = busy_q;
        age_d   = age_q;
        avail_d = avail_q;
        for (int r = 0; r < NREGS; r++) begin
            if (busy_q[r]) begin
                // entries younger than branch resolution (by their age this cycle) die on flush
                if (flush && (age_q[r] < FLUSH_L)) begin
                    busy_d[r]  = 1'b0;
                    age_d[r]   = '0;
                    avail_d[r] = '0;
                end else if (!hold) begin
                    if (age_q[r] == STAGES_L) begin
                        busy_d[r]  = 1'b0;
                        age_d[r]   = '0;
                        avail_d[r] = '0;
                    end else begin
                        age_d[r] = age_q[r] + SW'(1);
                    end
                end
            end
        end
        // youngest producer wins; a same-edge retire of the older one is overwritten here
        if (accept && sb.issue_we && (sb.issue_rd != '0)) begin
            busy_d[sb.issue_rd]  = 1'b1;
            age_d[sb.issue_rd]   = SW'(1);
            avail_d[sb.issue_rd] = avail_clamped;
        end
        busy_d[0] = 1'b0;
    end

    // scoreboard state register; reset beats hold, flush and issue
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            for (int r = 0; r < NREGS; r++) begin
                age_q[r]   <= '0;
                avail_q[r] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int r = 0; r < NREGS; r++) begin
                age_q[r]   <= age_d[r];
                avail_q[r] <= avail_d[r];
            end
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed bench for hazard_scoreboard against a queue-based model.
// Model keeps a list of in-flight writes, each with an age counter and availability stage.
// Outputs are sampled on the falling edge; the model advances after each rising edge.
module tb_hazard_scoreboard;
    localparam int RAW = 4;
    localparam int ST  = 4;
    localparam int FD  = 2;
    localparam int SWT = $clog2(ST + 1);

    logic clk = 1'b0;
    logic rst, hold, flush;
    int   n_chk = 0;
    int   n_err = 0;

    hazard_scoreboard_if #(.REG_AW(RAW), .STAGES(ST)) sbif ();

    hazard_scoreboard #(.REG_AW(RAW), .STAGES(ST), .FLUSH_DEPTH(FD)) dut (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .flush (flush),
        .sb    (sbif)
    );

    always #5 clk = ~clk;

    typedef struct {
        int rd;
        int age;
        int avail;
    } ent_t;

    ent_t q[$];
    logic m_stall;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // one source operand against the in-flight list
    task automatic model_src(input int s, input logic use_, output logic st,
                             output logic fv, output int fs);
        st = 1'b0;
        fv = 1'b0;
        fs = 0;
        if (sbif.issue_valid && use_ && s != 0) begin
            foreach (q[i]) begin
                if (q[i].rd == s) begin
                    if (q[i].age < q[i].avail) st = 1'b1;
                    else begin
                        fv = 1'b1;
                        fs = q[i].age;
                    end
                end
            end
        end
    endtask

    task automatic model_check();
        logic st_s, st_t, fv_s, fv_t;
        int   fs_s, fs_t;
        logic [31:0] bv;
        model_src(int'(sbif.issue_rs), sbif.issue_rs_use, st_s, fv_s, fs_s);
        model_src(int'(sbif.issue_rt), sbif.issue_rt_use, st_t, fv_t, fs_t);
        m_stall = st_s | st_t;
        bv = '0;
        foreach (q[i]) bv[q[i].rd] = 1'b1;
        check_eq("stall",    32'(sbif.stall),        32'(m_stall));
        check_eq("rs_valid", 32'(sbif.fwd_rs_valid), 32'(fv_s));
        check_eq("rs_stage", 32'(sbif.fwd_rs_stage), 32'(fs_s));
        check_eq("rt_valid", 32'(sbif.fwd_rt_valid), 32'(fv_t));
        check_eq("rt_stage", 32'(sbif.fwd_rt_stage), 32'(fs_t));
        check_eq("busy_vec", 32'(sbif.busy_vec),     bv);
    endtask

    // advance the in-flight list across one clock edge
    task automatic model_edge();
        ent_t nq[$];
        ent_t e;
        int   av;
        logic acc;
        if (rst) begin
            q.delete();
        end else begin
            foreach (q[i]) begin
                e = q[i];
                if (flush && e.age < FD) continue;
                if (!hold) begin
                    if (e.age >= ST) continue;
                    e.age++;
                end
                nq.push_back(e);
            end
            acc = sbif.issue_valid && !m_stall && !hold && !flush;
            if (acc && sbif.issue_we && sbif.issue_rd != 0) begin
                av = int'(sbif.issue_avail);
                if (av == 0) av = 1;
                if (av > ST) av = ST;
                for (int i = nq.size() - 1; i >= 0; i--)
                    if (nq[i].rd == int'(sbif.issue_rd)) nq.delete(i);
                e.rd = int'(sbif.issue_rd);
                e.age = 1;
                e.avail = av;
                nq.push_back(e);
            end
            q = nq;
        end
    endtask

    task automatic step(input logic r, input logic h, input logic f, input logic v,
                        input int rs, input int rt, input logic rsu, input logic rtu,
                        input int rd, input logic we, input int av);
        rst   = r;
        hold  = h;
        flush = f;
        sbif.issue_valid  = v;
        sbif.issue_rs     = RAW'(rs);
        sbif.issue_rt     = RAW'(rt);
        sbif.issue_rs_use = rsu;
        sbif.issue_rt_use = rtu;
        sbif.issue_rd     = RAW'(rd);
        sbif.issue_we     = we;
        sbif.issue_avail  = SWT'(av);
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        sbif.issue_valid = 1'b0; sbif.issue_rs = '0; sbif.issue_rt = '0;
        sbif.issue_rs_use = 1'b0; sbif.issue_rt_use = 1'b0;
        sbif.issue_rd = '0; sbif.issue_we = 1'b0; sbif.issue_avail = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        q.delete();
        idle(1);

        // ALU producer r3, then readers forwarding from stage 1 and 2
        step(0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 1);
        step(0, 0, 0, 1, 3, 0, 1, 0, 4, 1, 1);
        step(0, 0, 0, 1, 0, 3, 0, 1, 10, 1, 1);
        idle(4);
        // load r5 with immediate reader: stall then forward from stage 2
        step(0, 0, 0, 1, 0, 0, 0, 0, 5, 1, 2);
        step(0, 0, 0, 1, 5, 0, 1, 0, 11, 1, 1);
        step(0, 0, 0, 1, 5, 0, 1, 0, 11, 1, 1);
        idle(4);
        // hold freezes r6 at age 1
        step(0, 0, 0, 1, 0, 0, 0, 0, 6, 1, 3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 6, 0, 1, 0, 12, 1, 1);
        idle(5);
        // WAW on r7, reader picks the younger
        step(0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 1);
        step(0, 0, 0, 1, 0, 0, 0, 0, 7, 1, 2);
        step(0, 0, 0, 1, 7, 7, 1, 1, 0, 0, 1);
        idle(5);
        // flush kills the young r8 and the concurrent r9 issue
        step(0, 0, 0, 1, 0, 0, 0, 0, 8, 1, 1);
        step(0, 0, 1, 1, 0, 0, 0, 0, 9, 1, 1);
        idle(2);
        // r0 writes and reads, out-of-range avail values
        step(0, 0, 0, 1, 0, 0, 1, 1, 0, 1, 0);
        step(0, 0, 0, 1, 0, 0, 1, 1, 2, 1, 0);
        step(0, 0, 0, 1, 2, 0, 1, 0, 13, 1, 7);
        step(0, 0, 0, 1, 13, 13, 1, 1, 0, 0, 0);
        // reset mid-flight
        step(1, 0, 0, 1, 0, 0, 0, 0, 14, 1, 2);
        idle(1);

        // random traffic over a small register window to force collisions
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 10),
                 ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 80),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 7)),
                 ($urandom_range(0, 99) < 75),
                 int'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
